load_store_unit: RTL and testbench

- Multi-cycle data-memory access unit for the MIPS datapath.
- Core side: sized load/store requests (byte/half/word) with a sign/zero-extend select.
- Memory side: word-aligned requests with byte enables over a req/ready handshake.
- Loads: selects the addressed lane and sign- or zero-extends it to 32 bits. Stores: replicates narrow data onto byte lanes. Stalls the core while busy.

---
 rtl/load_store_unit.sv | 203 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sized load/store access unit with word-aligned memory handshake
module load_store_unit #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_out,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        timeout,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic             to_q, to_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      mwdata_q, mwdata_d;

  logic             bad_req;
  logic [3:0]       be_calc;
  logic [31:0]      wdata_calc;
  logic [31:0]      load_ext;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  assign bad_req = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);

  // Byte enables and lane replication are computed from the raw request and latched on accept.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (size)
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  always_comb begin
    rd_byte  = dm_rdata[{off_q, 3'b000} +: 8];
    rd_half  = dm_rdata[{off_q[1], 4'b0000} +: 16];
    load_ext = dm_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{sign_q & rd_half[15]}}, rd_half};
      default: load_ext = dm_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    write_d    = write_q;
    size_d     = size_q;
    sign_d     = sign_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    to_d       = 1'b0;
    req_d      = 1'b0;
    we_d       = 1'b0;
    maddr_d    = maddr_q;
    be_d       = be_q;
    mwdata_d   = mwdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_req) begin
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else begin
            state_d    = REQ;
            wait_cnt_d = '0;
            write_d    = mem_write;
            size_d     = size;
            sign_d     = sign;
            off_d      = addr[1:0];
            maddr_d    = {addr[31:2], 2'b00};
            be_d       = be_calc;
            mwdata_d   = wdata_calc;
            busy_d     = 1'b1;
            req_d      = 1'b1;
            we_d       = mem_write;
          end
        end
      end
      REQ: begin
        if (dm_ready) begin
          if (!write_q) rdata_d = load_ext;
          state_d    = FIN;
          done_d     = 1'b1;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d    = FIN;
          done_d     = 1'b1;
          to_d       = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          busy_d     = 1'b1;
          req_d      = 1'b1;
          we_d       = write_q;
        end
      end
      FIN: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      sign_q     <= 1'b0;
      off_q      <= 2'b00;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      be_q       <= '0;
      mwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      write_q    <= write_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      to_q       <= to_d;
      req_q      <= req_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      be_q       <= be_d;
      mwdata_q   <= mwdata_d;
    end
  end

  assign rdata_out  = rdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign timeout    = to_q;
  assign dm_req     = req_q;
  assign dm_we      = we_q;
  assign dm_addr    = maddr_q;
  assign dm_be      = be_q;
  assign dm_wdata   = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_out;
  logic        busy, done, misaligned, timeout;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  int total  = 0;
  int passed = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_write(mem_write),
    .size(size), .sign(sign), .addr(addr), .wdata(wdata),
    .rdata_out(rdata_out), .busy(busy), .done(done), .misaligned(misaligned),
    .timeout(timeout), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic launch(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_write = we; size = sz; sign = sg; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    launch(v.we, v.sz, v.sg, v.a, v.wd);
    if (v.mis) begin
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_mis"}, {31'b0, misaligned}, 32'd1);
      chk({tag, "_req"}, {31'b0, dm_req}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk({tag, "_mis_gone"}, {29'b0, dm_req, done, misaligned}, 32'd0);
    end else begin
      chk({tag, "_req"}, {30'b0, dm_req, busy}, 32'd3);
      chk({tag, "_done_early"}, {31'b0, done}, 32'd0);
      chk({tag, "_we"}, {31'b0, dm_we}, {31'b0, v.we});
      chk({tag, "_addr"}, dm_addr, {v.a[31:2], 2'b00});
      chk({tag, "_be"}, {28'b0, dm_be}, {28'b0, v.be});
      chk({tag, "_wdata"}, dm_wdata, v.mwd);
      dm_rdata = v.rd; dm_ready = 1'b1;
      @(negedge clk);
      dm_ready = 1'b0;
      if (!v.we) exp_rdata = v.res;
      chk({tag, "_done"}, {28'b0, done, busy, dm_req, timeout}, 32'h8);
      chk({tag, "_rdata"}, rdata_out, exp_rdata);
      @(negedge clk);
      chk({tag, "_after"}, {30'b0, done, dm_req}, 32'd0);
    end
  endtask

  initial begin
    int req_cycles;
    rst_n = 1'b0; start = 1'b0; mem_write = 1'b0; size = 2'b00; sign = 1'b0;
    addr = '0; wdata = '0; dm_ready = 1'b0; dm_rdata = '0;
    exp_rdata = '0;

    //        we    sz     sg    addr      wdata         rdata         mis   be       mwdata        result
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80FF1234, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h202, 32'h0,        32'hBEEF0000, 1'b0, 4'b1100, 32'h0,        32'h0000BEEF};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h202, 32'h0,        32'hBEEF0000, 1'b0, 4'b1100, 32'h0,        32'hFFFFBEEF};
    vecs[3]  = '{1'b0, 2'b10, 1'b1, 32'h300, 32'h0,        32'h80000001, 1'b0, 4'b1111, 32'h0,        32'h80000001};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h101, 32'h0,        32'h0000F700, 1'b0, 4'b0010, 32'h0,        32'h000000F7};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h200, 32'h0,        32'h12348001, 1'b0, 4'b0011, 32'h0,        32'hFFFF8001};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h402, 32'h1234ABCD, 32'hFFFFFFFF, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h500, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_flags", {26'b0, busy, done, misaligned, timeout, dm_req, dm_we}, 32'd0);
    chk("reset_rdata", rdata_out, 32'd0);
    chk("reset_be", {28'b0, dm_be}, 32'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Byte store with wait states: ready arrives on the third REQ cycle.
    launch(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ws_req%0d", c), {29'b0, dm_req, dm_we, busy}, 32'd7);
      chk($sformatf("ws_be%0d", c), {28'b0, dm_be}, 32'h2);
      chk($sformatf("ws_wd%0d", c), dm_wdata, 32'hA5A5A5A5);
      chk($sformatf("ws_addr%0d", c), dm_addr, 32'h100);
      chk($sformatf("ws_done%0d", c), {31'b0, done}, 32'd0);
      if (c == 2) dm_ready = 1'b1;
      @(negedge clk);
    end
    dm_ready = 1'b0;
    chk("ws_done", {28'b0, done, busy, dm_req, timeout}, 32'h8);
    chk("ws_rdata", rdata_out, exp_rdata);

    // Timeout with a stray start during REQ.
    launch(1'b0, 2'b10, 1'b1, 32'h600, 32'h0);
    req_cycles = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (dm_req) req_cycles++;
      if (c == 1) begin
        start = 1'b1; addr = 32'h700; mem_write = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("to_req_cycles", req_cycles, 32'd4);
    chk("to_flags", {28'b0, done, timeout, dm_req, busy}, 32'hC);
    chk("to_rdata", rdata_out, exp_rdata);
    @(negedge clk);
    chk("to_after", {29'b0, dm_req, done, busy}, 32'd0);
    @(negedge clk);
    chk("to_no_queue", {30'b0, dm_req, done}, 32'd0);

    // Reset in the second REQ cycle aborts silently.
    launch(1'b0, 2'b10, 1'b0, 32'h800, 32'h0);
    @(negedge clk);
    chk("rst_second_req", {31'b0, dm_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    chk("rst_flags", {26'b0, busy, done, misaligned, timeout, dm_req, dm_we}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_bus", dm_addr | dm_wdata | {28'b0, dm_be}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_no_done", {30'b0, done, dm_req}, 32'd0);

    launch(1'b1, 2'b01, 1'b0, 32'h0, 32'h5555AAAA);
    chk("post_rst_be", {28'b0, dm_be}, 32'h3);
    chk("post_rst_wd", dm_wdata, 32'hAAAAAAAA);
    chk("post_rst_req", {30'b0, dm_req, dm_we}, 32'd3);
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
    chk("post_rst_done", {28'b0, done, busy, dm_req, timeout}, 32'h8);
    chk("post_rst_rdata", rdata_out, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
